// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard stall/flush controller: FSM encoding,
// register-file constants, hazard flag bundle and the register match helper.
package hazard_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned ST_W   = 2;
    localparam int unsigned REM_W  = 2;

    localparam logic [ST_W-1:0] ST_RUN      = 2'd0;
    localparam logic [ST_W-1:0] ST_STALL    = 2'd1;
    localparam logic [ST_W-1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // One flag per stall-producing hazard class
    typedef struct packed {
        logic lu;   // load-use
        logic ba;   // branch after ALU producer
        logic bl;   // branch after load in EX
        logic bm;   // branch after load in MEM
    } hazard_t;

    // A producer matches a source only if it writes a real register
    function automatic logic reg_match(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] dst);
        return (dst != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Pure combinational hazard classifier for the instruction sitting in ID.
// Ports:
//   rs_addr_i, rt_addr_i   source registers of the ID instruction
//   uses_rt_i, branch_i    ID instruction reads RT / is a branch resolved in ID
//   id_ex_rd_i, id_ex_reg_write_i, id_ex_mem_read_i   producer in EX
//   ex_mem_rd_i, ex_mem_mem_read_i                     producer in MEM
//   hz_o                   LU/BA/BL/BM hazard flags
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    input  logic              uses_rt_i,
    input  logic              branch_i,
    input  logic [REG_AW-1:0] id_ex_rd_i,
    input  logic              id_ex_reg_write_i,
    input  logic              id_ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_mem_rd_i,
    input  logic              ex_mem_mem_read_i,
    output hazard_t           hz_o
);

    logic ex_rs_match;
    logic ex_rt_match;
    logic mem_any_match;

    always_comb begin
        ex_rs_match   = reg_match(rs_addr_i, id_ex_rd_i);
        ex_rt_match   = reg_match(rt_addr_i, id_ex_rd_i);
        mem_any_match = reg_match(rs_addr_i, ex_mem_rd_i) |
                        reg_match(rt_addr_i, ex_mem_rd_i);
    end

    // Branches compare both operands in ID, so RT always counts for them
    always_comb begin
        hz_o    = '0;
        hz_o.lu = id_ex_mem_read_i & (ex_rs_match | (uses_rt_i & ex_rt_match));
        hz_o.ba = branch_i & id_ex_reg_write_i & ~id_ex_mem_read_i &
                  (ex_rs_match | ex_rt_match);
        hz_o.bl = branch_i & id_ex_mem_read_i & (ex_rs_match | ex_rt_match);
        hz_o.bm = branch_i & ex_mem_mem_read_i & mem_any_match;
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline. Covers the hazards that
// forwarding cannot resolve (load-use, branch operands in flight, data-memory
// wait states), counts stalled cycles and flags memory timeouts.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   RS_ADDR, RT_ADDR, ID_UsesRT       ID instruction sources
//   ID_Branch, ID_Jump, BranchTaken   ID control-flow info
//   ID_EX_RD/RegWrite/MemRead         EX-stage producer
//   EX_MEM_RD/MemRead                 MEM-stage producer
//   MemReq, MemReady                  data-memory handshake
//   PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze
//                                     combinational pipeline controls
//   StallCount                        saturating stalled/frozen cycle count
//   MemError                          sticky memory timeout flag
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        RS_ADDR,
    input  logic [4:0]        RT_ADDR,
    input  logic              ID_UsesRT,
    input  logic              ID_Branch,
    input  logic              ID_Jump,
    input  logic              BranchTaken,
    input  logic [4:0]        ID_EX_RD,
    input  logic              ID_EX_RegWrite,
    input  logic              ID_EX_MemRead,
    input  logic [4:0]        EX_MEM_RD,
    input  logic              EX_MEM_MemRead,
    input  logic              MemReq,
    input  logic              MemReady,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush,
    output logic              Pipe_Freeze,
    output logic [CNT_W-1:0]  StallCount,
    output logic              MemError
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hazard_t hz;

    logic [ST_W-1:0]   state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              mem_error_q, mem_error_d;

    logic mw;
    logic any_hz;
    logic pc_write_c;
    logic if_id_write_c;
    logic if_id_flush_c;
    logic id_ex_flush_c;
    logic freeze_c;

    hazard_detect u_detect (
        .rs_addr_i         (RS_ADDR),
        .rt_addr_i         (RT_ADDR),
        .uses_rt_i         (ID_UsesRT),
        .branch_i          (ID_Branch),
        .id_ex_rd_i        (ID_EX_RD),
        .id_ex_reg_write_i (ID_EX_RegWrite),
        .id_ex_mem_read_i  (ID_EX_MemRead),
        .ex_mem_rd_i       (EX_MEM_RD),
        .ex_mem_mem_read_i (EX_MEM_MemRead),
        .hz_o              (hz)
    );

    always_comb begin
        mw     = MemReq & ~MemReady;
        any_hz = hz.lu | hz.ba | hz.bl | hz.bm;
    end

    // Next-state and control outputs; controls land in the detection cycle
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        freeze_c      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mw) begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    freeze_c      = 1'b1;
                    state_d       = ST_MEM_WAIT;
                end else if (any_hz) begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    id_ex_flush_c = 1'b1;
                    if (hz.bl) begin
                        rem_d   = 2'd1;
                        state_d = ST_STALL;
                    end
                end else begin
                    if_id_flush_c = (ID_Branch & BranchTaken) | ID_Jump;
                end
            end

            ST_STALL: begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                if (mw) begin
                    // rem is held so the leftover stall resumes after the wait
                    freeze_c = 1'b1;
                    state_d  = ST_MEM_WAIT;
                end else begin
                    id_ex_flush_c = 1'b1;
                    rem_d         = rem_q - 2'd1;
                    if (rem_d == 2'd0) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (mw) begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    freeze_c      = 1'b1;
                end else begin
                    // Completion cycle lets the pipeline advance; any
                    // outstanding stall is served from STALL next cycle
                    state_d = (rem_q != 2'd0) ? ST_STALL : ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
                rem_d   = 2'd0;
            end
        endcase

        // Controls sit at their idle values for the whole reset assertion
        if (!rst_n) begin
            pc_write_c    = 1'b1;
            if_id_write_c = 1'b1;
            if_id_flush_c = 1'b0;
            id_ex_flush_c = 1'b0;
            freeze_c      = 1'b0;
        end
    end

    // Wait-cycle counter, timeout flag and saturating stall counter
    always_comb begin
        wait_cnt_d  = '0;
        mem_error_d = mem_error_q;
        stall_cnt_d = stall_cnt_q;

        if (freeze_c) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q
                                                              : wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                mem_error_d = 1'b1;
            end
        end

        if (!pc_write_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            rem_q       <= '0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign PC_Write    = pc_write_c;
    assign IF_ID_Write = if_id_write_c;
    assign IF_ID_Flush = if_id_flush_c;
    assign ID_EX_Flush = id_ex_flush_c;
    assign Pipe_Freeze = freeze_c;
    assign StallCount  = stall_cnt_q;
    assign MemError    = mem_error_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural pipeline model.
module tb_hazard_stall_unit;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs, rt, idex_rd, exmem_rd;
    logic uses_rt, br, jmp, taken, idex_rw, idex_mr, exmem_mr, mreq, mrdy;
    logic pc_write, ifid_write, ifid_flush, idex_flush, freeze, mem_error;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int failures = 0;

    // Model: pending extra stall cycles, memory-wait flag, counters
    int m_extra;
    bit m_wait;
    int m_cnt;
    int m_wcnt;
    bit m_err;
    bit m_mw;
    bit m_bl;
    bit e_pcw, e_ifw, e_iff, e_exf, e_frz;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RS_ADDR        (rs),
        .RT_ADDR        (rt),
        .ID_UsesRT      (uses_rt),
        .ID_Branch      (br),
        .ID_Jump        (jmp),
        .BranchTaken    (taken),
        .ID_EX_RD       (idex_rd),
        .ID_EX_RegWrite (idex_rw),
        .ID_EX_MemRead  (idex_mr),
        .EX_MEM_RD      (exmem_rd),
        .EX_MEM_MemRead (exmem_mr),
        .MemReq         (mreq),
        .MemReady       (mrdy),
        .PC_Write       (pc_write),
        .IF_ID_Write    (ifid_write),
        .IF_ID_Flush    (ifid_flush),
        .ID_EX_Flush    (idex_flush),
        .Pipe_Freeze    (freeze),
        .StallCount     (stall_count),
        .MemError       (mem_error)
    );

    function automatic bit same_nz(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    task automatic clear_inputs();
        rs = 0; rt = 0; idex_rd = 0; exmem_rd = 0;
        uses_rt = 0; br = 0; jmp = 0; taken = 0;
        idex_rw = 0; idex_mr = 0; exmem_mr = 0; mreq = 0; mrdy = 1;
    endtask

    task automatic model_reset();
        m_extra = 0; m_wait = 0; m_cnt = 0; m_wcnt = 0; m_err = 0;
    endtask

    // Expected controls for the current cycle from model state and inputs
    task automatic model_eval(input bit in_reset);
        bit lu, ba, bm, hz, ex_hit;
        ex_hit = same_nz(rs, idex_rd) || same_nz(rt, idex_rd);
        lu   = idex_mr && (same_nz(rs, idex_rd) || (uses_rt && same_nz(rt, idex_rd)));
        ba   = br && idex_rw && !idex_mr && ex_hit;
        m_bl = br && idex_mr && ex_hit;
        bm   = br && exmem_mr && (same_nz(rs, exmem_rd) || same_nz(rt, exmem_rd));
        hz   = lu || ba || m_bl || bm;
        m_mw = mreq && !mrdy;
        e_pcw = 1; e_ifw = 1; e_iff = 0; e_exf = 0; e_frz = 0;
        if (in_reset) return;
        if (m_wait) begin
            if (m_mw) begin e_pcw = 0; e_ifw = 0; e_frz = 1; end
        end else if (m_mw) begin
            e_pcw = 0; e_ifw = 0; e_frz = 1;
        end else if (m_extra > 0 || hz) begin
            e_pcw = 0; e_ifw = 0; e_exf = 1;
        end else begin
            e_iff = (br && taken) || jmp;
        end
    endtask

    task automatic model_update();
        if (!e_pcw && m_cnt < CNT_MAX) m_cnt++;
        if (e_frz) begin
            m_wcnt++;
            if (m_wcnt >= TO) m_err = 1;
        end else begin
            m_wcnt = 0;
        end
        if (m_wait) begin
            if (!m_mw) m_wait = 0;
        end else if (m_mw) begin
            m_wait = 1;
        end else if (m_extra > 0) begin
            m_extra--;
        end else if (m_bl) begin
            m_extra = 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [CW-1:0] exp_cnt;
        exp_cnt = CW'(m_cnt);
        checks++;
        assert (pc_write === e_pcw) else begin
            failures++; $error("FAIL %s PC_Write got %b exp %b", tag, pc_write, e_pcw); end
        checks++;
        assert (ifid_write === e_ifw) else begin
            failures++; $error("FAIL %s IF_ID_Write got %b exp %b", tag, ifid_write, e_ifw); end
        checks++;
        assert (ifid_flush === e_iff) else begin
            failures++; $error("FAIL %s IF_ID_Flush got %b exp %b", tag, ifid_flush, e_iff); end
        checks++;
        assert (idex_flush === e_exf) else begin
            failures++; $error("FAIL %s ID_EX_Flush got %b exp %b", tag, idex_flush, e_exf); end
        checks++;
        assert (freeze === e_frz) else begin
            failures++; $error("FAIL %s Pipe_Freeze got %b exp %b", tag, freeze, e_frz); end
        checks++;
        assert (stall_count === exp_cnt) else begin
            failures++; $error("FAIL %s StallCount got %0d exp %0d", tag, stall_count, exp_cnt); end
        checks++;
        assert (mem_error === m_err) else begin
            failures++; $error("FAIL %s MemError got %b exp %b", tag, mem_error, m_err); end
    endtask

    // Fixed-value checks from the scenario descriptions
    task automatic check_cnt(input string tag, input int exp);
        logic [CW-1:0] e;
        e = CW'(exp);
        checks++;
        assert (stall_count === e) else begin
            failures++; $error("FAIL %s StallCount got %0d exp %0d", tag, stall_count, e); end
    endtask

    task automatic check_err(input string tag, input logic exp);
        checks++;
        assert (mem_error === exp) else begin
            failures++; $error("FAIL %s MemError got %b exp %b", tag, mem_error, exp); end
    endtask

    // Called at a negedge with inputs already driven; returns at next negedge
    task automatic cycle(input string tag);
        #1;
        model_eval(0);
        check_all(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0;
        #1;
        model_reset();
        model_eval(1);
        check_all(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        clear_inputs();
    endtask

    task automatic set_bl(input logic [4:0] r);
        clear_inputs();
        idex_mr = 1; idex_rw = 1; idex_rd = r; br = 1; rs = r; rt = 5'd9; taken = 1;
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        do_reset("reset");

        // Load-use: one stall, then resume
        idex_mr = 1; idex_rw = 1; idex_rd = 5; rs = 5; rt = 6; uses_rt = 1;
        cycle("lu_stall");
        clear_inputs();
        cycle("lu_resume");
        check_cnt("lu_cnt", 1);

        // Branch after load: two stalls, then taken-branch flush
        do_reset("reset_bl");
        set_bl(5'd8);
        cycle("bl_stall1");
        clear_inputs(); exmem_mr = 1; exmem_rd = 8; br = 1; rs = 8; taken = 1;
        cycle("bl_stall2");
        clear_inputs(); br = 1; rs = 8; taken = 1;
        cycle("bl_flush");
        check_cnt("bl_cnt", 2);

        // Register zero never matches
        do_reset("reset_r0");
        idex_mr = 1; idex_rd = 0; rs = 0; rt = 0; uses_rt = 1;
        cycle("r0_nostall");
        check_cnt("r0_cnt", 0);

        // Memory wait during a branch-after-load stall
        do_reset("reset_mw");
        set_bl(5'd8);
        cycle("mw_bl");
        clear_inputs(); mreq = 1; mrdy = 0;
        cycle("mw_f1");
        cycle("mw_f2");
        cycle("mw_f3");
        mrdy = 1;
        cycle("mw_done");
        clear_inputs();
        cycle("mw_rem_stall");
        cycle("mw_run");
        check_cnt("mw_cnt", 5);
        check_err("mw_noerr", 1'b0);

        // Timeout: six frozen cycles with a limit of four
        do_reset("reset_to");
        mreq = 1; mrdy = 0;
        for (int i = 0; i < 6; i++) begin
            cycle("to_freeze");
            if (i == 2) check_err("to_before", 1'b0);
            if (i == 3) check_err("to_set", 1'b1);
        end
        mrdy = 1;
        cycle("to_done");
        clear_inputs();
        cycle("to_idle1");
        cycle("to_idle2");
        check_err("to_sticky", 1'b1);

        // Reset while in STALL with hazard inputs still active
        do_reset("reset_mid");
        set_bl(5'd3);
        cycle("mid_bl");
        do_reset("rst_mid_stall");
        cycle("mid_after");

        // Saturation with a 4-bit counter
        idex_mr = 1; idex_rd = 7; rs = 7;
        for (int i = 0; i < 20; i++) cycle("sat_stall");
        check_cnt("sat_cnt", CNT_MAX);
        clear_inputs();
        cycle("sat_idle");

        // Randomized traffic
        do_reset("reset_rand");
        for (int i = 0; i < 600; i++) begin
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            idex_rd = 5'($urandom_range(0, 3));
            exmem_rd = 5'($urandom_range(0, 3));
            uses_rt = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1));
            jmp = ($urandom_range(0, 5) == 0);
            taken = 1'($urandom_range(0, 1));
            idex_rw = 1'($urandom_range(0, 1));
            idex_mr = 1'($urandom_range(0, 1));
            exmem_mr = 1'($urandom_range(0, 1));
            mreq = ($urandom_range(0, 3) == 0);
            mrdy = ($urandom_range(0, 2) != 0);
            cycle("rand");
            if (i == 300) do_reset("rand_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall/flush controller for the 5-stage MIPS pipeline. It complements the operand-forwarding logic by covering the hazards forwarding cannot resolve: load-use, branch operands still in flight, and data-memory wait states. It sits beside the ID stage and drives the PC, the IF/ID write enables and the pipeline-register flush/freeze controls. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
- MEM_TIMEOUT, 64: MemReady wait cycles before MemError sets.
- CNT_W, 16: width of StallCount.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- RS_ADDR, RT_ADDR  in  5 each  source registers of the instruction in ID.
- ID_UsesRT  in  1  ID instruction reads RT.
- ID_Branch  in  1  ID instruction is a branch resolved in ID.
- ID_Jump  in  1  ID instruction is a jump.
- BranchTaken  in  1  branch outcome from the ID comparator.
- ID_EX_RD  in  5; ID_EX_RegWrite, ID_EX_MemRead  in  1 each.
- EX_MEM_RD  in  5; EX_MEM_MemRead  in  1.
- MemReq  in  1  MEM stage has an active data access.
- MemReady  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID update enable.
- IF_ID_Flush  out  1  zero the IF/ID register.
- ID_EX_Flush  out  1  insert a bubble into ID/EX.
- Pipe_Freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- StallCount  out  CNT_W  saturating count of stalled or frozen cycles.
- MemError  out  1  sticky memory timeout.

## Operation
- Hazard detection is combinational. Register 0 never matches.
  - **LU (load-use):** ID_EX_MemRead, and ID_EX_RD equals RS_ADDR, or equals RT_ADDR with ID_UsesRT. Needs 1 stall.
  - **BA (branch after ALU):** ID_Branch, ID_EX_RegWrite, !ID_EX_MemRead, and an RS/RT match on ID_EX_RD. Needs 1 stall.
  - **BL (branch after load):** ID_Branch, ID_EX_MemRead, and an RS/RT match on ID_EX_RD. Needs 2 stalls.
  - **BM (branch after load, one stage later):** ID_Branch, EX_MEM_MemRead, and an RS/RT match on EX_MEM_RD. Needs 1 stall.
  - **MW (memory wait):** MemReq && !MemReady.
- **Stall action:** PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
- **Freeze action:** PC_Write=0, IF_ID_Write=0, Pipe_Freeze=1, ID_EX_Flush=0.
- **FSM states:** RUN, STALL, MEM_WAIT. A 2-bit remaining-stall counter `rem` runs alongside.
  - **RUN**
    - MW: apply freeze, go to MEM_WAIT. MW has priority over every other hazard.
    - Else, any hazard: apply stall this cycle. BL loads rem=1 and goes to STALL. LU, BA and BM stay in RUN.
    - Else: normal operation. If (ID_Branch && BranchTaken) || ID_Jump, assert IF_ID_Flush for this cycle.
  - **STALL**
    - Stall action is applied unconditionally; hazard inputs are ignored.
    - rem decrements each cycle. Return to RUN when rem==0 after the decrement.
    - MW takes precedence: go to MEM_WAIT and keep rem frozen.
  - **MEM_WAIT**
    - Freeze while MW holds.
    - Once MW is false, return to STALL if rem!=0, otherwise RUN.
    - A wait counter counts frozen cycles. Reaching MEM_TIMEOUT sets MemError; it clears only on reset.
    - The freeze continues after a timeout.
- IF_ID_Flush is never asserted during a stall or a freeze. The branch is re-evaluated after the stall.
- StallCount increments on every cycle with PC_Write=0 and saturates at all-ones.

## Timing
- **Reset (asynchronous):** state=RUN, rem=0, wait counter=0, StallCount=0, MemError=0.
  - While rst_n is low: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, Pipe_Freeze=0.
- Control outputs are combinational from the state and the same-cycle inputs, so the stall lands in the detection cycle.
- Only state, counters and flags are registered.
- **Latencies:** LU/BA/BM give 1 stall cycle; BL gives exactly 2. MW freezes for as many cycles as MemReady stays low.
- **Reset mid-operation:** an in-progress STALL or MEM_WAIT is abandoned immediately.

## Structure
- Shared package `hazard_pkg`:
  - FSM state encoding: RUN=2'd0, STALL=2'd1, MEM_WAIT=2'd2.
  - REG_ZERO=5'd0 constant.
- Natural sub-module: `hazard_detect`, the pure combinational LU/BA/BL/BM match logic, reusable by verification models.
- Counters and the FSM live in the top module.

## Test plan
- **Load-use:** lw to $5 in ID/EX, then add reading $5 in ID. Expect PC_Write=0 and ID_EX_Flush=1 for 1 cycle, then resume. StallCount=1.
- **Branch after load:** lw to $8, then beq reading $8. Expect 2 stall cycles (STALL visited, rem 1→0). Once taken, IF_ID_Flush=1 for 1 cycle. StallCount=2.
- **Register zero:** lw to $0, then add reading $0. Expect no stall.
- **Memory wait:** MemReq=1 with MemReady low for 3 cycles during a BL stall. Expect Pipe_Freeze for 3 cycles, rem held at 1, then 1 remaining stall cycle. StallCount=5.
- **Timeout:** MEM_TIMEOUT=4 and MemReady held low for 6 cycles. Expect MemError to rise on the 4th frozen cycle and stay high after MemReady returns.
- **Reset and saturation:** drive rst_n low mid-STALL; expect immediate RUN with outputs at reset values. Separately, with CNT_W=4, run 20 stall cycles and expect StallCount to hold at 15.
